// File: rtl/sel_dist_pkg.sv
// sel_dist_pkg: lane select encoding shared by the 1-to-4 distributor
package sel_dist_pkg;
    typedef logic [1:0] lane_idx_t;
    localparam lane_idx_t SEL_A = 2'b00;
    localparam lane_idx_t SEL_B = 2'b01;
    localparam lane_idx_t SEL_C = 2'b10;
    localparam lane_idx_t SEL_D = 2'b11;
endpackage

// File: rtl/sel_dist_1_4_lane.sv
// dist_lane: one-entry holding register with valid flag
module dist_lane #(parameter int W = 2) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data_out
);
    // data is kept on pop so the lane output only changes on a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            if (push) data_out <= data_in;
            valid <= push | (valid & ~pop);
        end
    end
endmodule

// File: rtl/sel_dist_1_4.sv
// sel_dist_1_4: registered 1-to-4 distributor with per-lane valid/ready
module sel_dist_1_4
    import sel_dist_pkg::*;
#(parameter int W = 2) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  lane_idx_t    in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic         a_valid,
    output logic         b_valid,
    output logic         c_valid,
    output logic         d_valid,
    input  logic         a_ready,
    input  logic         b_ready,
    input  logic         c_ready,
    input  logic         d_ready,
    output logic [3:0]   full
);
    logic [3:0]   lane_ready;
    logic [3:0]   push;
    logic [W-1:0] lane_data [4];
    assign lane_ready = {d_ready, c_ready, b_ready, a_ready};
    // a busy lane only blocks the producer when that lane is the target
    assign in_ready = rst_n & (~full[in_sel] | lane_ready[in_sel]);
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign push[i] = in_valid & in_ready & (in_sel == lane_idx_t'(i));
        dist_lane #(.W(W)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push[i]),
            .data_in  (in_data),
            .pop      (full[i] & lane_ready[i]),
            .valid    (full[i]),
            .data_out (lane_data[i])
        );
    end
    assign a       = lane_data[SEL_A];
    assign b       = lane_data[SEL_B];
    assign c       = lane_data[SEL_C];
    assign d       = lane_data[SEL_D];
    assign a_valid = full[SEL_A];
    assign b_valid = full[SEL_B];
    assign c_valid = full[SEL_C];
    assign d_valid = full[SEL_D];
endmodule

// File: tb/tb_sel_dist_1_4.sv
// tb_sel_dist_1_4: directed self-checking bench for the 1-to-4 distributor
module tb_sel_dist_1_4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_data = '0;
    logic [1:0] in_sel = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] a, b, c, d;
    logic       a_valid, b_valid, c_valid, d_valid;
    logic       a_ready = 1'b1, b_ready = 1'b1, c_ready = 1'b1, d_ready = 1'b1;
    logic [3:0] full;
    int checks = 0;
    int failures = 0;

    sel_dist_1_4 #(.W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d),
        .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
        .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
        .full(full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic [3:0] r);
        {d_ready, c_ready, b_ready, a_ready} = r;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (full !== 4'b0000 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags full=%b in_ready=%b exp full=0000 in_ready=0", full, in_ready);
        end
        checks++;
        if ({a, b, c, d} !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got %h exp 00", {a, b, c, d});
        end
        #4 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_single_push();
        set_ready(4'b1111);
        in_sel = 2'b10; in_data = 2'b11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (c !== 2'b11 || full !== 4'b0100 || c_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_push c=%b full=%b exp c=11 full=0100", c, full);
        end
        tick();
        checks++;
        if (full !== 4'b0000 || c !== 2'b11) begin
            failures++;
            $display("FAIL single_pop full=%b c=%b exp full=0000 c=11", full, c);
        end
    endtask

    task automatic test_stream();
        set_ready(4'b1111);
        for (int v = 0; v < 4; v++) begin
            in_sel = 2'b00; in_data = 2'(v); in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready word %0d got %b exp 1", v, in_ready);
            end
            tick();
            checks++;
            if (a !== 2'(v) || a_valid !== 1'b1 || full !== 4'b0001) begin
                failures++;
                $display("FAIL stream_data word %0d a=%0d full=%b exp a=%0d full=0001", v, a, full, v);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (a_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain a_valid=%b exp 0", a_valid);
        end
    endtask

    task automatic test_back_pressure();
        set_ready(4'b1101);
        in_sel = 2'b01; in_data = 2'b01; in_valid = 1'b1;
        tick();
        in_data = 2'b10;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall_ready got %b exp 0", in_ready);
        end
        tick();
        checks++;
        if (b !== 2'b01 || b_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold b=%b b_valid=%b in_ready=%b exp b=01 valid=1 ready=0", b, b_valid, in_ready);
        end
        b_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (b !== 2'b10 || b_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_new_word b=%b b_valid=%b exp b=10 valid=1", b, b_valid);
        end
        tick();
        checks++;
        if (full !== 4'b0000) begin
            failures++;
            $display("FAIL bp_drain full=%b exp 0000", full);
        end
    endtask

    task automatic test_isolation();
        logic [1:0] sels [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
        logic [1:0] vals [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
        set_ready(4'b0000);
        for (int i = 0; i < 4; i++) begin
            in_sel = sels[i]; in_data = vals[i]; in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL iso_ready push %0d got %b exp 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (full !== 4'b1111 || {a, b, c, d} !== 8'b01_10_00_11) begin
            failures++;
            $display("FAIL iso_state full=%b abcd=%b exp full=1111 abcd=01100011", full, {a, b, c, d});
        end
    endtask

    task automatic test_pop_all_push();
        set_ready(4'b1111);
        in_sel = 2'b00; in_data = 2'b10; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL popall_ready got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        set_ready(4'b0000);
        checks++;
        if (full !== 4'b0001 || a !== 2'b10) begin
            failures++;
            $display("FAIL popall_state full=%b a=%b exp full=0001 a=10", full, a);
        end
    endtask

    task automatic test_reset_mid();
        a_ready = 1'b1;
        in_sel = 2'b01; in_data = 2'b01; in_valid = 1'b1;
        tick();
        a_ready = 1'b0;
        in_sel = 2'b10; in_data = 2'b10;
        tick();
        in_sel = 2'b01; in_data = 2'b11;
        checks++;
        if (full !== 4'b0110) begin
            failures++;
            $display("FAIL mid_setup full=%b exp 0110", full);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (full !== 4'b0000 || in_ready !== 1'b0 || {b, c} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset full=%b in_ready=%b bc=%b exp 0000/0/0000", full, in_ready, {b, c});
        end
        in_valid = 1'b0;
        set_ready(4'b0000);
        tick();
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || full !== 4'b0000) begin
            failures++;
            $display("FAIL mid_release in_ready=%b full=%b exp 1/0000", in_ready, full);
        end
        tick();
        checks++;
        if (full !== 4'b0000) begin
            failures++;
            $display("FAIL mid_no_replay full=%b exp 0000", full);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_stream();
        test_back_pressure();
        test_isolation();
        test_pop_all_push();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
